// File: rtl/alu_core.sv
// Execute-stage MIPS ALU: registered single-cycle ops, iterative shift-add MULT/MULTU
// writing HI/LO, and a sticky BREAK halt, behind a start/busy/done handshake.
module alu_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             brk
);

   localparam int DW = 2 * WIDTH;
   localparam int HW = WIDTH / 2;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_ADDU  = 4'b0100;
   localparam logic [3:0] OP_SUBU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_LUI   = 4'b1010;
   localparam logic [3:0] OP_BREAK = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_FIX  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             brk_q, brk_d;
   logic [DW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_q, sign_d;

   logic [WIDTH-1:0] sum_s, diff_s, alu_res_s, a_abs_s, b_abs_s;
   logic             alu_ovf_s, add_ovf_s, sub_ovf_s, slt_s;
   logic [DW-1:0]    prod_s;

   // Single-cycle datapath results and signed-overflow detection
   always_comb begin
      sum_s     = a + b;
      diff_s    = a - b;
      add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      slt_s     = $signed(a) < $signed(b);
      a_abs_s   = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
      b_abs_s   = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
      prod_s    = sign_q ? ({DW{1'b0}} - acc_q) : acc_q;
      alu_res_s = {WIDTH{1'b0}};
      alu_ovf_s = 1'b0;
      case (control)
         OP_AND:  alu_res_s = a & b;
         OP_OR:   alu_res_s = a | b;
         OP_ADD:  begin alu_res_s = sum_s;  alu_ovf_s = add_ovf_s; end
         OP_XOR:  alu_res_s = a ^ b;
         OP_ADDU: alu_res_s = sum_s;
         OP_SUBU: alu_res_s = diff_s;
         OP_SUB:  begin alu_res_s = diff_s; alu_ovf_s = sub_ovf_s; end
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
         OP_LUI:  alu_res_s = {b[HW-1:0], {HW{1'b0}}};
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Control FSM: issue, multiply iterations, sign fix-up and halt
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      brk_d      = brk_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (control)
                  OP_MULT, OP_MULTU: begin
                     if (control == OP_MULT) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_abs_s};
                        mplier_d = b_abs_s;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                     end else begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        sign_d   = 1'b0;
                     end
                     acc_d   = {DW{1'b0}};
                     cnt_d   = CW'(WIDTH);
                     busy_d  = 1'b1;
                     state_d = ST_MUL;
                  end
                  OP_BREAK: begin
                     brk_d      = 1'b1;
                     result_d   = {WIDTH{1'b0}};
                     zero_d     = 1'b1;
                     overflow_d = 1'b0;
                     done_d     = 1'b1;
                     state_d    = ST_HALT;
                  end
                  default: begin
                     result_d   = alu_res_s;
                     zero_d     = (alu_res_s == {WIDTH{1'b0}});
                     overflow_d = alu_ovf_s;
                     done_d     = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_FIX: begin
            hi_d       = prod_s[DW-1:WIDTH];
            lo_d       = prod_s[WIDTH-1:0];
            result_d   = prod_s[WIDTH-1:0];
            zero_d     = (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
            overflow_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any multiply and clears HALT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         result_q   <= {WIDTH{1'b0}};
         zero_q     <= 1'b1;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         brk_q      <= 1'b0;
         mcand_q    <= {DW{1'b0}};
         mplier_q   <= {WIDTH{1'b0}};
         acc_q      <= {DW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         sign_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         brk_q      <= brk_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign brk      = brk_q;

endmodule
